// File: rtl/reg_access_ctrl.sv
// Button-driven command front end for the 32x32 register file: synchronise, debounce, then a small write/show FSM.
// Define REG_ACCESS_AUTO_INC_EN to source write addresses from an internal wrapping counter instead of Sw_Addr.
module reg_access_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 20
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Btn_Write,
  input  logic       Btn_Read,
  input  logic       Btn_Next,
  input  logic [4:0] Sw_Addr,
  input  logic [1:0] Sw_Data_Sel,
  output logic [4:0] Addr,
  output logic       Write_Reg,
  output logic       Read_Reg,
  output logic [1:0] choose,
  output logic       Busy,
  output logic [1:0] State
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    WRITE = 2'b01,
    SHOW  = 2'b10
  } state_t;

  localparam logic [19:0] DB_LAST = 20'(DEBOUNCE_CYCLES - 1);

  // Bit order in the button vectors: 0 = write, 1 = read, 2 = next.
  logic [2:0] btn_raw;
  logic [2:0] sync1;
  logic [2:0] sync2;
  logic [2:0] db;
  logic [2:0] db_q;
  logic [2:0] ev;
  logic       ev_write;
  logic       ev_read;
  logic       ev_next;
  state_t     state;

  assign btn_raw  = {Btn_Next, Btn_Read, Btn_Write};
  assign ev_write = ev[0];
  assign ev_read  = ev[1];
  assign ev_next  = ev[2];
  assign State    = state;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  for (genvar i = 0; i < 3; i++) begin : g_debounce
    logic [19:0] cnt;
    logic        level;

    always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
        cnt   <= '0;
        level <= 1'b0;
      end else if (sync2[i] == level) begin
        cnt <= '0;
      end else if (cnt == DB_LAST) begin
        level <= ~level;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 20'd1;
      end
    end

    assign db[i] = level;
  end

  // Rising-edge events are registered, so the FSM acts one cycle after db settles.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      db_q <= '0;
      ev   <= '0;
    end else begin
      db_q <= db;
      ev   <= db & ~db_q;
    end
  end

`ifdef REG_ACCESS_AUTO_INC_EN
  logic [4:0] wr_addr;
`endif

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      Addr      <= '0;
      Write_Reg <= 1'b0;
      Read_Reg  <= 1'b0;
      choose    <= '0;
      Busy      <= 1'b0;
`ifdef REG_ACCESS_AUTO_INC_EN
      wr_addr   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (ev_write) begin
            state     <= WRITE;
            Busy      <= 1'b1;
            Write_Reg <= 1'b1;
            choose    <= Sw_Data_Sel;
`ifdef REG_ACCESS_AUTO_INC_EN
            Addr      <= wr_addr;
`else
            Addr      <= Sw_Addr;
`endif
          end else if (ev_read) begin
            state    <= SHOW;
            Busy     <= 1'b1;
            Read_Reg <= 1'b1;
            Addr     <= Sw_Addr;
            choose   <= '0;
          end
        end
        WRITE: begin
          state     <= IDLE;
          Busy      <= 1'b0;
          Write_Reg <= 1'b0;
`ifdef REG_ACCESS_AUTO_INC_EN
          wr_addr   <= wr_addr + 5'd1;
`endif
        end
        SHOW: begin
          // Exit wins over a lane advance arriving in the same cycle.
          if (ev_read) begin
            state    <= IDLE;
            Busy     <= 1'b0;
            Read_Reg <= 1'b0;
            choose   <= '0;
          end else if (ev_next) begin
            choose <= choose + 2'd1;
          end
        end
        default: begin
          state     <= IDLE;
          Busy      <= 1'b0;
          Write_Reg <= 1'b0;
          Read_Reg  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_access_ctrl.sv
// Directed bench for reg_access_ctrl with DEBOUNCE_CYCLES=4; edge k is the first edge that samples a button high.
// Define REG_ACCESS_AUTO_INC_EN for both files to exercise the write-address counter.
module tb_reg_access_ctrl;

  localparam int DC = 4;

`ifdef REG_ACCESS_AUTO_INC_EN
  localparam int ADDR_W1    = 0;
  localparam int ADDR_W2    = 1;
  localparam int ADDR_W_RST = 0;
`else
  localparam int ADDR_W1    = 9;
  localparam int ADDR_W2    = 17;
  localparam int ADDR_W_RST = 21;
`endif

  logic       Clk = 1'b0;
  logic       Reset;
  logic       Btn_Write;
  logic       Btn_Read;
  logic       Btn_Next;
  logic [4:0] Sw_Addr;
  logic [1:0] Sw_Data_Sel;
  logic [4:0] Addr;
  logic       Write_Reg;
  logic       Read_Reg;
  logic [1:0] choose;
  logic       Busy;
  logic [1:0] State;

  int checks    = 0;
  int fails     = 0;
  int wr_pulses = 0;
  int rd_cycles = 0;
  int wr_base;
  int rd_base;

  reg_access_ctrl #(.DEBOUNCE_CYCLES(DC)) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .Btn_Write   (Btn_Write),
    .Btn_Read    (Btn_Read),
    .Btn_Next    (Btn_Next),
    .Sw_Addr     (Sw_Addr),
    .Sw_Data_Sel (Sw_Data_Sel),
    .Addr        (Addr),
    .Write_Reg   (Write_Reg),
    .Read_Reg    (Read_Reg),
    .choose      (choose),
    .Busy        (Busy),
    .State       (State)
  );

  initial forever #5 Clk = ~Clk;

  // Running tallies of strobe and read-select cycles, sampled before each edge's update.
  always @(posedge Clk) begin
    if (Write_Reg) wr_pulses = wr_pulses + 1;
    if (Read_Reg)  rd_cycles = rd_cycles + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic applyStimulus(input logic w, input logic r, input logic n,
                               input logic [4:0] a, input logic [1:0] sel);
    Btn_Write   = w;
    Btn_Read    = r;
    Btn_Next    = n;
    Sw_Addr     = a;
    Sw_Data_Sel = sel;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input string tag, input int addr, input int wr, input int rd,
                          input int ch, input int busy, input int st);
    checkOutput({tag, ".Addr"},      32'(Addr),      addr);
    checkOutput({tag, ".Write_Reg"}, 32'(Write_Reg), wr);
    checkOutput({tag, ".Read_Reg"},  32'(Read_Reg),  rd);
    checkOutput({tag, ".choose"},    32'(choose),    ch);
    checkOutput({tag, ".Busy"},      32'(Busy),      busy);
    checkOutput({tag, ".State"},     32'(State),     st);
  endtask

  initial begin
    int next_exp [5];
    next_exp = '{1, 2, 3, 0, 1};

    applyStimulus(0, 0, 0, 5'd0, 2'd0);
    Reset = 1'b1;
    tick(3);
    checkAll("reset", 0, 0, 0, 0, 0, 0);
    Reset = 1'b0;
    tick(2);

    // Held write button: strobe at k+7 only, exactly once.
    wr_base = wr_pulses;
    applyStimulus(1, 0, 0, 5'd9, 2'd2);
    tick(7);
    checkOutput("wr_k6.Write_Reg", 32'(Write_Reg), 0);
    tick(1);
    checkAll("wr_k7", ADDR_W1, 1, 0, 2, 1, 1);
    tick(1);
    checkAll("wr_k8", ADDR_W1, 0, 0, 2, 0, 0);
    tick(20);
    checkOutput("wr_held_single", 32'(wr_pulses - wr_base), 1);
    applyStimulus(0, 0, 0, 5'd9, 2'd2);
    tick(10);
    checkOutput("idle_hold.choose", 32'(choose), 2);

    // Read pulse of 3 cycles is filtered out.
    applyStimulus(0, 1, 0, 5'd3, 2'd0);
    tick(3);
    applyStimulus(0, 0, 0, 5'd3, 2'd0);
    tick(15);
    checkOutput("short_read.Read_Reg", 32'(Read_Reg), 0);
    checkOutput("short_read.State", 32'(State), 0);

    // 10-cycle read pulse opens a session.
    applyStimulus(0, 1, 0, 5'd3, 2'd0);
    tick(8);
    checkAll("read_open", 3, 0, 1, 0, 1, 2);
    tick(2);
    applyStimulus(0, 0, 0, 5'd3, 2'd0);
    tick(10);

    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 0, 1, 5'd3, 2'd0);
      tick(8);
      checkOutput($sformatf("next%0d.choose", i), 32'(choose), next_exp[i]);
      applyStimulus(0, 0, 0, 5'd3, 2'd0);
      tick(10);
      if (i == 2) begin
        wr_base = wr_pulses;
        applyStimulus(1, 0, 0, 5'd3, 2'd0);
        tick(8);
        applyStimulus(0, 0, 0, 5'd3, 2'd0);
        tick(10);
        checkOutput("show_wr_ignored", 32'(wr_pulses - wr_base), 0);
        checkOutput("show_wr.State", 32'(State), 2);
        checkOutput("show_wr.Read_Reg", 32'(Read_Reg), 1);
      end
    end

    applyStimulus(0, 1, 0, 5'd3, 2'd0);
    tick(8);
    checkAll("read_close", 3, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 5'd3, 2'd0);
    tick(10);

    // Write and read rising together: write wins, read is dropped.
    wr_base = wr_pulses;
    rd_base = rd_cycles;
    applyStimulus(1, 1, 0, 5'd17, 2'd1);
    tick(8);
    checkAll("both", ADDR_W2, 1, 0, 1, 1, 1);
    applyStimulus(0, 0, 0, 5'd17, 2'd1);
    tick(10);
    checkOutput("both.wr_pulses", 32'(wr_pulses - wr_base), 1);
    checkOutput("both.rd_cycles", 32'(rd_cycles - rd_base), 0);
    checkOutput("both.State", 32'(State), 0);

    // Open a session at lane 2, then reset mid-cycle.
    applyStimulus(0, 1, 0, 5'd21, 2'd3);
    tick(8);
    applyStimulus(0, 0, 0, 5'd21, 2'd3);
    tick(10);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(0, 0, 1, 5'd21, 2'd3);
      tick(8);
      applyStimulus(0, 0, 0, 5'd21, 2'd3);
      tick(10);
    end
    checkAll("pre_reset", 21, 0, 1, 2, 1, 2);
    applyStimulus(1, 0, 0, 5'd21, 2'd3);
    #2 Reset = 1'b1;
    #1;
    checkAll("async_reset", 0, 0, 0, 0, 0, 0);
    tick(2);
    Reset = 1'b0;
    tick(1);
    tick(6);
    checkOutput("post_reset_k6.Write_Reg", 32'(Write_Reg), 0);
    tick(1);
    checkOutput("post_reset_k7.Write_Reg", 32'(Write_Reg), 1);
    checkOutput("post_reset_k7.Addr", 32'(Addr), ADDR_W_RST);
    checkOutput("post_reset_k7.choose", 32'(choose), 3);
    applyStimulus(0, 0, 0, 5'd21, 2'd3);
    tick(10);

`ifdef REG_ACCESS_AUTO_INC_EN
    Reset = 1'b1;
    tick(2);
    Reset = 1'b0;
    tick(2);
    for (int i = 0; i < 33; i++) begin
      applyStimulus(1, 0, 0, 5'd7, 2'd0);
      tick(8);
      checkOutput($sformatf("autoinc%0d.Addr", i), 32'(Addr), i % 32);
      applyStimulus(0, 0, 0, 5'd7, 2'd0);
      tick(10);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
